// File: rtl/tick_period_monitor.sv
// tick_period_monitor
// Measures the number of clk cycles between successive rising edges of a
// tick strobe and publishes each measurement through a valid/ack holding
// register. Flags a stalled source (timeout) and measurements lost while
// the previous one was still unconsumed (overrun).

module tick_period_monitor #(
    parameter int unsigned WIDTH      = 23,
    parameter int unsigned MAX_PERIOD = 8_000_000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             tick,
    input  logic             period_ack,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STALL
    } state_t;

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MAX_PERIOD);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic             tick_d;
    logic             tick_edge;
    logic             capture;

    // Rising-edge detect and capture qualification for the current cycle
    // NOTE: every signal assigned in always_comb is given a value on every
    // path, so no latch can be inferred.
    always_comb begin
        tick_edge = tick & ~tick_d;
        capture   = en & tick_edge & (state == MEASURE);
    end

    // Delayed copy of tick; reset to 0 so a tick already high after reset
    // release is seen as an edge
    // NOTE: all sequential state uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick;
        end
    end

    // Measurement FSM: interval counter and stall detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            count   <= '0;
            timeout <= 1'b0;
        end else if (!en) begin
            // Disable wins over any edge; the interval in progress is lost
            state   <= IDLE;
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_edge) begin
                        count <= ONE;
                        state <= MEASURE;
                    end else begin
                        count <= '0;
                    end
                end
                MEASURE: begin
                    if (tick_edge) begin
                        // Edge cycle counts as 1 of the next interval
                        count <= ONE;
                    end else if (count == MAX_COUNT) begin
                        // Count holds at the limit so it can never wrap
                        state   <= STALL;
                        timeout <= 1'b1;
                    end else begin
                        count <= count + ONE;
                    end
                end
                STALL: begin
                    // Interval that spanned the stall is meaningless; restart
                    if (tick_edge) begin
                        count   <= ONE;
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

    // Holding register with valid/ack handshake and sticky overrun
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (capture) begin
            if (!period_valid || period_ack) begin
                // Slot is free, or is being freed this very cycle
                period       <= count;
                period_valid <= 1'b1;
                if (period_ack) begin
                    overrun <= 1'b0;
                end
            end else begin
                // Consumer still owns the old value; drop the new one
                overrun <= 1'b1;
            end
        end else if (period_ack && period_valid) begin
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed testbench for tick_period_monitor with a scoreboard of expected
// periods; a monitor pops and compares whenever the DUT loads a new value.

module tb_tick_period_monitor;

    localparam int unsigned WIDTH = 23;
    localparam int unsigned MAXP  = 16;

    logic             clk = 1'b0;
    logic             nrst;
    logic             en;
    logic             tick;
    logic             period_ack;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             overrun;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    tick_period_monitor #(
        .WIDTH     (WIDTH),
        .MAX_PERIOD(MAXP)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .tick        (tick),
        .period_ack  (period_ack),
        .period      (period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 ns after posedge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One rising edge of tick, held high for hi cycles, next edge gap cycles
    // later. push_val >= 0 is the period this edge is expected to publish.
    // ack_at >= 0 pulses period_ack in that cycle offset from the edge.
    task automatic edge_then(input int gap, input int push_val, input int ack_at,
                             input int hi = 1);
        if (push_val >= 0) exp_q.push_back(push_val);
        for (int i = 0; i < gap; i++) begin
            tick       = (i < hi);
            period_ack = (i == ack_at);
            cycle();
        end
        tick       = 1'b0;
        period_ack = 1'b0;
    endtask

    // Monitor: a load happened when valid rises, or stays high across an ack
    always @(posedge clk) begin
        logic was_valid;
        logic ack_seen;
        int   exp_val;
        was_valid = period_valid;
        ack_seen  = period_ack;
        #2;
        if (nrst && period_valid && (!was_valid || ack_seen)) begin
            check("scoreboard_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                check("period_value", period, exp_val);
            end
        end
    end

    initial begin
        nrst       = 1'b0;
        en         = 1'b1;
        tick       = 1'b0;
        period_ack = 1'b0;
        #23;
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_overrun", overrun, 0);
        cycle();
        nrst = 1'b1;
        cycle();

        // Regular 1-cycle pulses with ack 5 cycles after each edge
        edge_then(12, -1, 5);
        check("first_edge_no_valid", period_valid, 0);
        edge_then(12, 12, 5);
        edge_then(12, 12, 5);
        edge_then(16, 12, 5);
        edge_then(10, 16, 5);             // interval equal to MAX_PERIOD
        check("no_overrun_with_ack", overrun, 0);

        // No ack: hold, drop, ack, then capture coinciding with ack
        edge_then(13, 10, -1);
        edge_then(13, -1, -1);            // 13 dropped
        check("overrun_set", overrun, 1);
        check("period_held", period, 10);
        period_ack = 1'b1;
        cycle();
        period_ack = 1'b0;
        check("ack_clears_valid", period_valid, 0);
        check("ack_clears_overrun", overrun, 0);
        edge_then(14, 14, -1);            // 13 gap + ack cycle = 14
        edge_then(11, -1, -1);            // 14 dropped
        check("overrun_set_again", overrun, 1);
        edge_then(16, 11, 0);             // capture and ack together
        check("coincide_valid", period_valid, 1);
        check("coincide_overrun", overrun, 0);
        check("coincide_period", period, 11);

        // Timeout after MAX_PERIOD + 1 cycles of silence
        check("timeout_before_limit", timeout, 0);
        cycle();
        check("timeout_at_limit", timeout, 1);
        period_ack = 1'b1;
        cycle();
        period_ack = 1'b0;
        cycle();
        cycle();
        edge_then(10, -1, -1);            // edge out of stall: no capture
        check("timeout_cleared", timeout, 0);
        check("stall_no_capture", period_valid, 0);

        // Wide tick: high 5, low 7
        edge_then(12, 10, 5, 5);
        edge_then(12, 12, 5, 5);
        edge_then(12, 12, -1, 5);         // leave 12 held

        // Stall, then disable for 3 cycles with a held measurement
        repeat (5) cycle();
        check("timeout_before_disable", timeout, 1);
        en = 1'b0;
        repeat (3) cycle();
        check("disable_clears_timeout", timeout, 0);
        check("disable_keeps_valid", period_valid, 1);
        check("disable_keeps_period", period, 12);
        en = 1'b1;
        edge_then(10, -1, 5);             // first edge after enable
        check("reenable_first_no_capture", period, 12);
        edge_then(14, 10, -1);

        // Reset mid-measurement with a held value
        check("valid_before_reset", period_valid, 1);
        nrst = 1'b0;
        #2;
        check("inrst_period", period, 0);
        check("inrst_valid", period_valid, 0);
        check("inrst_timeout", timeout, 0);
        check("inrst_overrun", overrun, 0);
        cycle();
        nrst = 1'b1;
        edge_then(12, -1, 5);             // tick high in first cycle after release
        edge_then(8, 12, 5);
        repeat (3) cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
